// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared definitions for the instruction sequencer: FSM state
//            encoding, program-counter select codes and decoded opcodes.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // Program counter select
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INCR = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b10;
  localparam logic [1:0] PS_OFST = 2'b11;

  // Opcodes with sequencing side effects; all others are ALU operations
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BRZ  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

endpackage
`default_nettype wire

// File: rtl/seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : seq_watchdog
// Purpose  : Counts FETCH cycles that pass without a memory acknowledge and
//            flags the cycle whose miss brings the count to MEM_TIMEOUT.
// Ports    : clk, rst (async, active-low)
//            clear   - hold the count at zero (sequencer outside FETCH)
//            enable  - a FETCH cycle without mem_ack
//            timeout - this missed cycle is the MEM_TIMEOUT-th one
// Revision : 1.0 - initial release
// ============================================================================
module seq_watchdog #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [7:0] LAST_MISS = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // Asserted in the cycle whose miss would take the count to MEM_TIMEOUT,
  // so the sequencer leaves FETCH on that same edge. An ack in that cycle
  // drops enable and therefore wins over the timeout.
  assign timeout = enable && (count == LAST_MISS);

endmodule
`default_nettype wire

// File: rtl/instr_seq.sv
`default_nettype none
// ============================================================================
// Module   : instr_seq
// Purpose  : Instruction sequencer FSM: IDLE -> FETCH -> DECODE -> EXEC,
//            with HALT and (optionally) a FETCH-timeout FAULT state.
// Ports    : clk, rst (async, active-low), run
//            mem_req/mem_ack - instruction fetch handshake
//            ir_ld           - load instruction register (with mem_ack)
//            opcode, zero    - IR opcode field and ALU zero flag
//            PS              - PC select (hold/incr/load/offset)
//            reg_we, halted, fault
// Config   : SEQ_WATCHDOG_EN - enables the FETCH watchdog and FAULT state;
//            without it FETCH waits forever and fault is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module instr_seq
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       mem_req,
  input  logic       mem_ack,
  output logic       ir_ld,
  input  logic [3:0] opcode,
  input  logic       zero,
  output logic [1:0] PS,
  output logic       reg_we,
  output logic       halted,
  output logic       fault
);

  state_t state, state_nxt;

`ifdef SEQ_WATCHDOG_EN
  logic wd_timeout;

  // Count is held at zero whenever the FSM is outside FETCH, so every FETCH
  // entry starts from a cleared count.
  seq_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != S_FETCH),
    .enable ((state == S_FETCH) && !mem_ack),
    .timeout(wd_timeout)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    ir_ld     = 1'b0;
    PS        = PS_HOLD;
    reg_we    = 1'b0;

    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_ld     = 1'b1;
          state_nxt = S_DECODE;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wd_timeout) begin
          state_nxt = S_FAULT;
        end
`endif
      end
      S_DECODE: begin
        state_nxt = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (opcode == OP_JMP) begin
          PS = PS_LOAD;
        end else if (opcode == OP_BRZ) begin
          PS = zero ? PS_OFST : PS_INCR;
        end else begin
          PS     = PS_INCR;
          reg_we = 1'b1;
        end
        // The instruction always completes; run only decides what follows.
        state_nxt = run ? S_FETCH : S_IDLE;
      end
      S_HALT, S_FAULT: begin
        if (!run) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign halted = (state == S_HALT);
`ifdef SEQ_WATCHDOG_EN
  assign fault  = (state == S_FAULT);
`else
  assign fault  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_seq
// Purpose  : Scoreboard bench for instr_seq. The driver applies one input
//            vector per cycle and queues the hand-derived output vector for
//            that cycle; the monitor pops and compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       mem_ack = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       zero = 1'b0;
  logic       mem_req, ir_ld, reg_we, halted, fault;
  logic [1:0] PS;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [5:0] v;   // {mem_req, ir_ld, PS[1:0], reg_we, halted}
    logic       f;   // fault
  } exp_t;

  exp_t sb[$];

  instr_seq #(.MEM_TIMEOUT(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .mem_req(mem_req),
    .mem_ack(mem_ack),
    .ir_ld  (ir_ld),
    .opcode (opcode),
    .zero   (zero),
    .PS     (PS),
    .reg_we (reg_we),
    .halted (halted),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] observed();
    return {mem_req, ir_ld, PS, reg_we, halted, fault};
  endfunction

  task automatic compare(input string name, input logic [6:0] req);
    logic [6:0] act;
    act = observed();
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got {mreq,irld,PS,we,halt,fault}=%b required %b", name, act, req);
    end
  endtask

  // Monitor: every cycle with a queued expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      compare(e.name, {e.v, e.f});
    end
  end

  // Apply inputs for one cycle, queue what the outputs must be, advance.
  task automatic step(input string name, input logic r, input logic a,
                      input logic [3:0] op, input logic z,
                      input logic [5:0] v, input logic f);
    exp_t e;
    run = r; mem_ack = a; opcode = op; zero = z;
    e.name = name; e.v = v; e.f = f;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] O_NONE  = 6'b00_00_0_0;
  localparam logic [5:0] O_FREQ  = 6'b10_00_0_0;
  localparam logic [5:0] O_FACK  = 6'b11_00_0_0;
  localparam logic [5:0] O_ALU   = 6'b00_01_1_0;
  localparam logic [5:0] O_INCR  = 6'b00_01_0_0;
  localparam logic [5:0] O_OFST  = 6'b00_11_0_0;
  localparam logic [5:0] O_LOAD  = 6'b00_10_0_0;
  localparam logic [5:0] O_HALT  = 6'b00_00_0_1;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, queue=%0d required 0", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    // Reset held: all outputs low, FSM parked in IDLE even with run=1.
    step("reset_run0", 1'b0, 1'b0, 4'h0, 1'b0, O_NONE, 1'b0);
    step("reset_run1", 1'b1, 1'b1, 4'h0, 1'b0, O_NONE, 1'b0);
    rst = 1'b1;
    step("idle_run0",  1'b0, 1'b0, 4'h1, 1'b0, O_NONE, 1'b0);

    // ALU instruction, immediate ack: PS 00,00,01; FETCH again on cycle 4
    step("alu_idle",   1'b1, 1'b0, 4'h1, 1'b0, O_NONE, 1'b0);
    step("alu_fetch",  1'b1, 1'b1, 4'h1, 1'b0, O_FACK, 1'b0);
    step("alu_decode", 1'b1, 1'b0, 4'h1, 1'b0, O_NONE, 1'b0);
    step("alu_exec",   1'b1, 1'b0, 4'h1, 1'b0, O_ALU,  1'b0);

    // BRZ taken (one wait cycle first)
    step("brz1_fwait", 1'b1, 1'b0, 4'hD, 1'b1, O_FREQ, 1'b0);
    step("brz1_fetch", 1'b1, 1'b1, 4'hD, 1'b1, O_FACK, 1'b0);
    step("brz1_dec",   1'b1, 1'b1, 4'hD, 1'b1, O_NONE, 1'b0); // ack ignored
    step("brz1_exec",  1'b1, 1'b0, 4'hD, 1'b1, O_OFST, 1'b0);
    // BRZ not taken
    step("brz0_fetch", 1'b1, 1'b1, 4'hD, 1'b0, O_FACK, 1'b0);
    step("brz0_dec",   1'b1, 1'b0, 4'hD, 1'b0, O_NONE, 1'b0);
    step("brz0_exec",  1'b1, 1'b1, 4'hD, 1'b0, O_INCR, 1'b0);

    // Ack delayed 5 cycles: mem_req high for 6, ir_ld only with the ack; JMP
    for (int i = 0; i < 5; i++)
      step("dly_wait", 1'b1, 1'b0, 4'hC, 1'b0, O_FREQ, 1'b0);
    step("dly_ack",    1'b1, 1'b1, 4'hC, 1'b0, O_FACK, 1'b0);
    step("jmp_dec",    1'b1, 1'b0, 4'hC, 1'b0, O_NONE, 1'b0);
    step("jmp_exec",   1'b1, 1'b0, 4'hC, 1'b0, O_LOAD, 1'b0);

    // HALT: no EXEC, holds with run=1, leaves on run=0
    step("hlt_fetch",  1'b1, 1'b1, 4'hF, 1'b0, O_FACK, 1'b0);
    step("hlt_dec",    1'b1, 1'b0, 4'hF, 1'b0, O_NONE, 1'b0);
    step("hlt_1",      1'b1, 1'b0, 4'hF, 1'b0, O_HALT, 1'b0);
    step("hlt_2",      1'b1, 1'b1, 4'hF, 1'b0, O_HALT, 1'b0);
    step("hlt_run0",   1'b0, 1'b0, 4'hF, 1'b0, O_HALT, 1'b0);
    step("hlt_idle",   1'b0, 1'b0, 4'hF, 1'b0, O_NONE, 1'b0);

`ifdef SEQ_WATCHDOG_EN
    // No ack: FAULT after 4 FETCH cycles, held until run=0
    step("wd_idle",    1'b1, 1'b0, 4'h1, 1'b0, O_NONE, 1'b0);
    for (int i = 0; i < 4; i++)
      step("wd_fetch", 1'b1, 1'b0, 4'h1, 1'b0, O_FREQ, 1'b0);
    step("wd_fault1",  1'b1, 1'b0, 4'h1, 1'b0, O_NONE, 1'b1);
    step("wd_fault2",  1'b1, 1'b1, 4'h1, 1'b0, O_NONE, 1'b1);
    step("wd_run0",    1'b0, 1'b0, 4'h1, 1'b0, O_NONE, 1'b1);
    step("wd_cleared", 1'b0, 1'b0, 4'h1, 1'b0, O_NONE, 1'b0);
    // Ack on the 4th FETCH cycle wins over the timeout
    step("wdk_idle",   1'b1, 1'b0, 4'h1, 1'b0, O_NONE, 1'b0);
    for (int i = 0; i < 3; i++)
      step("wdk_fetch", 1'b1, 1'b0, 4'h1, 1'b0, O_FREQ, 1'b0);
    step("wdk_ack",    1'b1, 1'b1, 4'h1, 1'b0, O_FACK, 1'b0);
    step("wdk_dec",    1'b1, 1'b0, 4'h1, 1'b0, O_NONE, 1'b0);
    step("wdk_exec",   1'b0, 1'b0, 4'h1, 1'b0, O_ALU,  1'b0);
    step("wdk_idle2",  1'b0, 1'b0, 4'h1, 1'b0, O_NONE, 1'b0);
`else
    // No watchdog: FETCH keeps waiting well past MEM_TIMEOUT, never faults
    step("nwd_idle",   1'b1, 1'b0, 4'h1, 1'b0, O_NONE, 1'b0);
    for (int i = 0; i < 8; i++)
      step("nwd_fetch", 1'b1, 1'b0, 4'h1, 1'b0, O_FREQ, 1'b0);
    step("nwd_ack",    1'b1, 1'b1, 4'h1, 1'b0, O_FACK, 1'b0);
    step("nwd_dec",    1'b1, 1'b0, 4'h1, 1'b0, O_NONE, 1'b0);
    step("nwd_exec",   1'b0, 1'b0, 4'h1, 1'b0, O_ALU,  1'b0);
    step("nwd_idle2",  1'b0, 1'b0, 4'h1, 1'b0, O_NONE, 1'b0);
`endif

    // Asynchronous reset in the middle of EXEC
    step("rst_idle",   1'b1, 1'b0, 4'h1, 1'b0, O_NONE, 1'b0);
    step("rst_fetch",  1'b1, 1'b1, 4'h1, 1'b0, O_FACK, 1'b0);
    step("rst_dec",    1'b1, 1'b0, 4'h1, 1'b0, O_NONE, 1'b0);
    run = 1'b1; mem_ack = 1'b0; opcode = 4'h1; zero = 1'b0;
    #1;
    compare("rst_pre_exec", {O_ALU, 1'b0});
    rst = 1'b0;
    #1;
    compare("rst_async", {O_NONE, 1'b0});
    begin
      exp_t e;
      e.name = "rst_held"; e.v = O_NONE; e.f = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    step("rel_idle",   1'b1, 1'b1, 4'h1, 1'b0, O_NONE, 1'b0); // IDLE: ack ignored
    step("rel_fetch",  1'b1, 1'b1, 4'h1, 1'b0, O_FACK, 1'b0);
    step("rel_dec",    1'b0, 1'b0, 4'h1, 1'b0, O_NONE, 1'b0);
    step("rel_exec",   1'b0, 1'b0, 4'h1, 1'b0, O_ALU,  1'b0);
    step("rel_end",    1'b0, 1'b0, 4'h1, 1'b0, O_NONE, 1'b0);

    // Let the monitor drain the scoreboard (bounded)
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: queue=%0d required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
